// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  flush;
  logic                  stall_request;
  logic                  done;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, operand_1, operand_2, flush,
    input  stall_request, done, hi, lo
  );

  modport slave (
    input  start, op, operand_1, operand_2, flush,
    output stall_request, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU unit writing a 64-bit HI/LO result
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  md
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_stall;
  logic            w_done;

  logic [CW-1:0]   r_cnt;
  logic            r_is_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic            w_sign1;
  logic            w_sign2;
  logic [W-1:0]    w_mag1;
  logic [W-1:0]    w_mag2;

  logic [W:0]      w_mul_sum;
  logic [2*W-1:0]  w_mul_next;
  logic [W:0]      w_div_shift;
  logic [W+1:0]    w_div_diff;
  logic            w_div_ok;
  logic [W-1:0]    w_div_rem;
  logic [2*W-1:0]  w_div_next;
  logic [2*W-1:0]  w_acc_next;
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_quo_fix;
  logic [W-1:0]    w_rem_fix;

  assign w_sign1 = ~md.op[0] & md.operand_1[W-1];
  assign w_sign2 = ~md.op[0] & md.operand_2[W-1];
  assign w_mag1  = w_sign1 ? -md.operand_1 : md.operand_1;
  assign w_mag2  = w_sign2 ? -md.operand_2 : md.operand_2;

  // Multiply: add the multiplicand into the upper half, then shift the whole product right.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_b[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

  // Divide: upper half is the partial remainder, lower half collects quotient bits.
  assign w_div_shift = {r_acc[2*W-1:W], r_a[W-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
  assign w_div_ok    = ~w_div_diff[W+1];
  assign w_div_rem   = w_div_ok ? w_div_diff[W-1:0] : w_div_shift[W-1:0];
  assign w_div_next  = {w_div_rem, r_acc[W-2:0], w_div_ok};

  assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

  // A zero divisor leaves remainder = |dividend|, so the sign fix restores the raw dividend.
  assign w_prod_fix = r_neg_q ? -w_acc_next : w_acc_next;
  assign w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -w_acc_next[W-1:0] : w_acc_next[W-1:0]);
  assign w_rem_fix  = r_neg_r ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (md.start && !md.flush) begin
          w_state_next = RUN;
          w_stall      = 1'b1;
        end
      end
      RUN: begin
        w_stall = 1'b1;
        if (r_cnt == LAST_ITER) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (md.flush) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (md.flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (md.start) begin
            r_is_div <= md.op[1];
            r_neg_q  <= w_sign1 ^ w_sign2;
            r_neg_r  <= md.op[1] & w_sign1;
            r_div0   <= md.op[1] & (md.operand_2 == '0);
            r_a      <= w_mag1;
            r_b      <= w_mag2;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_a <= {r_a[W-2:0], 1'b0};
          end else begin
            r_b <= {1'b0, r_b[W-1:1]};
          end
          if (r_cnt == LAST_ITER) begin
            if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*W-1:W];
              r_lo <= w_prod_fix[W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md.stall_request = w_stall;
  assign md.done          = w_done;
  assign md.hi            = r_hi;
  assign md.lo            = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if #(.DATA_WIDTH(32)) md ();
  mult_div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .md(md.slave));

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last_res = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0)       r = {a, 32'hFFFFFFFF};
        else if (op == 2'b11) r = {a % b, a / b};
        else                  r = {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Entered at a negedge; returns at the negedge of the done cycle (or after the cycle budget).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [63:0] res, output int lat);
    bit stall_ok = 1'b1;
    bit hold_ok  = 1'b1;
    md.op = op; md.operand_1 = a; md.operand_2 = b; md.start = 1'b1;
    #1;
    if (!md.stall_request) stall_ok = 1'b0;
    lat = -1;
    res = 64'hx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (md.done) begin
        lat = c;
        res = {md.hi, md.lo};
        if (md.stall_request) stall_ok = 1'b0;
        break;
      end
      if (!md.stall_request) stall_ok = 1'b0;
      if (c == 16 && {md.hi, md.lo} !== last_res) hold_ok = 1'b0;
      if (hold) begin
        md.op = 2'($urandom); md.operand_1 = $urandom; md.operand_2 = $urandom;
      end else begin
        md.start = 1'b0;
      end
    end
    check("latency", 64'(lat), 64'd33);
    check("stall_profile", 64'(stall_ok), 64'd1);
    check("hilo_hold_in_run", 64'(hold_ok), 64'd1);
  endtask

  logic [1:0]  d_op  [8] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
  logic [31:0] d_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9,
                             32'd100, 32'h80000000, 32'd5, 32'hFFFFFFF9};
  logic [31:0] d_b   [8] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2,
                             32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [63:0] d_exp [8] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000,
                             64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E, 64'h00000000_80000000,
                             64'h00000005_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF};

  initial begin
    logic [63:0] res;
    logic [63:0] exp;
    int lat;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bit saw_done;

    rst = 1'b1;
    md.start = 1'b0; md.flush = 1'b0; md.op = 2'b00;
    md.operand_1 = 32'd0; md.operand_2 = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_hilo", {md.hi, md.lo}, 64'd0);
    check("reset_done", 64'(md.done), 64'd0);
    check("reset_stall", 64'(md.stall_request), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], 1'b0, res, lat);
      check($sformatf("directed_%0d", i), res, d_exp[i]);
      last_res = res;
      @(negedge clk);
    end

    // Flush mid-DIVU, then a fresh start in the following cycle.
    md.op = 2'b11; md.operand_1 = 32'd1000; md.operand_2 = 32'd3; md.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      md.start = 1'b0;
    end
    md.flush = 1'b1;
    @(negedge clk);
    md.flush = 1'b0;
    #1;
    check("flush_stall_low", 64'(md.stall_request), 64'd0);
    check("flush_no_done", 64'(md.done), 64'd0);
    check("flush_hilo_kept", {md.hi, md.lo}, last_res);
    run_op(2'b01, 32'd123456, 32'd789, 1'b0, res, lat);
    check("after_flush_res", res, ref_model(2'b01, 32'd123456, 32'd789));
    last_res = res;

    // Start held high with changing operands; only the sampled operands matter.
    @(negedge clk);
    run_op(2'b10, 32'hFFFF0000, 32'd9, 1'b1, res, lat);
    check("held_start_op1", res, ref_model(2'b10, 32'hFFFF0000, 32'd9));
    last_res = res;
    @(negedge clk);
    run_op(2'b00, 32'h12345678, 32'hFEDCBA98, 1'b0, res, lat);
    check("held_start_op2", res, ref_model(2'b00, 32'h12345678, 32'hFEDCBA98));
    last_res = res;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rop = 2'($urandom);
      ra = pick();
      rb = pick();
      exp = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, 1'b0, res, lat);
      check($sformatf("rand_%0d_op%0d_%h_%h", i, rop, ra, rb), res, exp);
      last_res = res;
    end

    // Reset in the middle of a run.
    @(negedge clk);
    md.op = 2'b00; md.operand_1 = 32'd77; md.operand_2 = 32'd55; md.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      md.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_hilo", {md.hi, md.lo}, 64'd0);
    check("rst_mid_stall", 64'(md.stall_request), 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (md.done) saw_done = 1'b1;
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(saw_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage: the consumer of the ID stage's `operand_1`/`operand_2` for MULT, MULTU, DIV and DIVU.
- Accepts one operation per start pulse and runs 32 radix-2 iterations.
- Holds the pipeline through `stall_request` while running, then presents a 64-bit HI/LO result with a one-cycle `done` pulse for the HI/LO write-back path.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width; the iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  bit1: 0=multiply, 1=divide; bit0: 0=signed, 1=unsigned (00 MULT, 01 MULTU, 10 DIV, 11 DIVU).
- operand_1  input  32  multiplicand/dividend (rs); sampled with start.
- operand_2  input  32  multiplier/divisor (rt); sampled with start.
- flush  input  1  synchronous abort, e.g. from an exception or branch squash.
- stall_request  output  1  pipeline hold request.
- done  output  1  one-cycle result-valid pulse.
- hi  output  32  product[63:32] or remainder.
- lo  output  32  product[31:0] or quotient.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; hi=0; lo=0; done=0; iteration counter=0. Reset overrides start and flush, and aborts any operation in progress; no done follows.
- States: IDLE, RUN, DONE.
- IDLE, start=1, flush=0:
  - latch op; latch |operand_1| and |operand_2| (raw values if unsigned);
  - latch sign flags: quotient/product negative = sign1 XOR sign2 (signed ops only); remainder negative = sign1 (DIV only);
  - clear the 64-bit accumulator; counter=0; go to RUN.
- RUN: one iteration per cycle; counter increments; after the iteration with counter==31, go to DONE.
  - Multiply: shift-add on magnitudes; 64-bit product.
  - Divide: restoring; shift the remainder left, bring in the next dividend bit, subtract the divisor if no borrow, shift the quotient bit in.
- Final iteration edge (RUN->DONE): hi/lo written with the sign-corrected result.
  - Multiply: {hi,lo} = negate-if-flag(product).
  - Divide: lo = negate-if-flag(quotient); hi = negate-if-flag(remainder).
- DONE: done=1 for exactly this cycle; next state IDLE. A start in this cycle is ignored.
- Latency: start high in cycle 0; RUN in cycles 1..32; done=1 in cycle 33. Back-to-back ops: the next start is accepted in cycle 34.
- stall_request = (state==IDLE & start & ~flush) | (state==RUN). It is low in the DONE cycle so EX advances and captures hi/lo.
- hi/lo hold their last result at all other times, including during RUN and after flush.
- start while RUN/DONE: ignored; operands are not resampled.
- flush=1 at any edge: state=IDLE, counter=0; hi/lo unchanged; no done.
  - flush with start in IDLE: no operation begins.
- Divide by zero (operand_2==0, DIV or DIVU): lo=32'hFFFFFFFF, hi=operand_1 as sampled (unsigned-interpreted, no sign correction). Full 33-cycle latency, done asserted, no exception.
- Signed overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (natural wrap of the magnitude negate).
- Magnitude of 0x80000000 is 0x80000000, treated as an unsigned 32-bit quantity; all internal datapaths are 33-bit or wider where borrow is needed.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF*0xFFFFFFFF, start in cycle 0 -> stall_request high cycles 0..32; done only in cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD(-3)*0x00000007 -> {hi,lo}=0xFFFFFFFF_FFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 5/0 and DIV 0xFFFFFFF9/0 -> lo=0xFFFFFFFF, hi=operand_1 (5 / 0xFFFFFFF9); done in cycle 33.
- Start DIVU, flush in cycle 10 -> stall_request low from cycle 11; no done; hi/lo keep their prior values. New start in cycle 11 -> done in cycle 44.
- Start held high continuously with new operands each cycle -> only cycle-0 operands used. Second op accepted in cycle 34, done in cycle 67. rst in cycle 20 of a run -> hi=lo=0, IDLE, no done.
